// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants for the digit scanner
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low {dp,g..a} patterns with dp off, indexed by hex nibble (entry 0 is rightmost)
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex nibble to active-low a..g decoder
module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  import seg_pkg::*;

  assign seg = SEG_TABLE[nibble][6:0];

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - free-running 4-digit common-anode display scanner
// Inputs are staged on load and committed only at frame boundaries so a frame never tears.
module seg_scan #(
  parameter int DIV   = 100000,
  parameter int BLANK = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dig_en,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic [7:0]  seg_cat,
  output logic [3:0]  seg_an,
  output logic        frame_start
);
  import seg_pkg::*;

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   stage_data;
  logic [3:0]    stage_en;
  logic [3:0]    stage_dp;
  logic [15:0]   disp_data;
  logic [3:0]    disp_en;
  logic [3:0]    disp_dp;
  logic          pending;
  logic          slot_end;
  logic          boundary;
  logic          active;
  logic [3:0]    nibble;
  logic [6:0]    seg7;

  assign slot_end = (cnt == CW'(DIV - 1));
  assign boundary = slot_end && (idx == 2'd3);
  assign active   = (cnt >= CW'(BLANK)) && disp_en[idx];
  assign nibble   = disp_data[{idx, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg7)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A load on the boundary cycle bypasses staging so the newest value is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_data <= '0;
      stage_en   <= '0;
      stage_dp   <= '0;
      disp_data  <= '0;
      disp_en    <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        stage_data <= data;
        stage_en   <= dig_en;
        stage_dp   <= dp;
        pending    <= 1'b1;
      end
      if (boundary && (pending || load)) begin
        disp_data <= load ? data   : stage_data;
        disp_en   <= load ? dig_en : stage_en;
        disp_dp   <= load ? dp     : stage_dp;
        pending   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_an      <= AN_OFF;
      seg_cat     <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (active) begin
        seg_an  <= ~(4'b0001 << idx);
        seg_cat <= {~disp_dp[idx], seg7};
      end else begin
        seg_an  <= AN_OFF;
        seg_cat <= SEG_OFF;
      end
    end
  end

endmodule
